// File: rtl/fir_4tap.sv
// Four-tap unit-coefficient FIR (4-sample moving sum) for a 16-bit unsigned ADC stream.
// One sample is captured, the four taps are summed one per cycle, and the result is
// published together with a single-cycle done strobe that also cues the next ADC sample.
module fir_4tap (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        enable,
    output logic [17:0] data_out,
    output logic        calculation_done
);

    localparam int unsigned NumTaps = 4;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Index of the last tap; reaching it in ACC finishes the sum.
    localparam logic [1:0] LastTap = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] tap_q [NumTaps];
    logic [15:0] tap_d [NumTaps];
    logic [17:0] acc_q, acc_d;
    logic [1:0]  k_q, k_d;
    logic [17:0] data_out_q, data_out_d;
    logic        done_q, done_d;

    // Running sum including the tap selected by k; 18 bits cannot overflow for 4 taps.
    logic [17:0] acc_sum;

    // Capture is allowed only while not summing.
    logic can_capture;

    assign can_capture = (state_q == StIdle) || (state_q == StDone);
    assign acc_sum     = acc_q + {2'b00, tap_q[k_q]};

    // Next-state: capture/shift, accumulate one tap per cycle, publish and strobe.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        k_d        = k_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        for (int i = 0; i < NumTaps; i++) begin
            tap_d[i] = tap_q[i];
        end

        case (state_q)
            StIdle, StDone: begin
                if (can_capture && enable) begin
                    tap_d[0] = data_in;
                    for (int i = 1; i < NumTaps; i++) begin
                        tap_d[i] = tap_q[i-1];
                    end
                    acc_d   = 18'd0;
                    k_d     = 2'd0;
                    state_d = StAcc;
                end else begin
                    state_d = StIdle;
                end
            end
            StAcc: begin
                acc_d = acc_sum;
                k_d   = k_q + 2'd1;
                if (k_q == LastTap) begin
                    data_out_d = acc_sum;
                    done_d     = 1'b1;
                    state_d    = StDone;
                end
            end
            default: begin
                // Unreachable encoding: fall back to idle without strobing.
                state_d = StIdle;
            end
        endcase
    end

    // State registers; asynchronous reset discards any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= 18'd0;
            k_q        <= 2'd0;
            data_out_q <= 18'd0;
            done_q     <= 1'b0;
            for (int i = 0; i < NumTaps; i++) begin
                tap_q[i] <= 16'd0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            for (int i = 0; i < NumTaps; i++) begin
                tap_q[i] <= tap_d[i];
            end
        end
    end

    assign data_out         = data_out_q;
    assign calculation_done = done_q;

endmodule

// File: tb/tb_fir_4tap.sv
// Self-checking bench for fir_4tap: directed scenarios plus randomized traffic,
// compared each cycle against a transaction-level moving-sum model.
module tb_fir_4tap;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        enable;
    logic [17:0] data_out;
    logic        calculation_done;

    fir_4tap dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_in          (data_in),
        .enable           (enable),
        .data_out         (data_out),
        .calculation_done (calculation_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: the last four accepted samples, a busy countdown, expected outputs.
    int          hist [4];
    int          busy;
    logic [17:0] exp_out;
    logic        exp_done;

    logic [17:0] seen  [$];
    logic [17:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = 0;
        busy     = 0;
        exp_out  = '0;
        exp_done = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [15:0] din);
        exp_done = 1'b0;
        if (busy == 0) begin
            if (en) begin
                for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'(din);
                busy    = 4;
            end
        end else begin
            busy--;
            if (busy == 0) begin
                exp_done = 1'b1;
                exp_out  = 18'(hist[0] + hist[1] + hist[2] + hist[3]);
            end
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check shortly after.
    task automatic drive_cycle(input logic rst, input logic en, input logic [15:0] din);
        @(negedge clk);
        rst_n   = rst;
        enable  = en;
        data_in = din;
        @(posedge clk);
        if (!rst) model_reset();
        else model_step(en, din);
        #1;
        check_eq("data_out", data_out, exp_out);
        check_eq("done", {17'd0, calculation_done}, {17'd0, exp_done});
        if (calculation_done === 1'b1) seen.push_back(data_out);
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_out", data_out, 18'd0);
        check_eq("async_rst_done", {17'd0, calculation_done}, 18'd0);
    endtask

    task automatic check_seq(input string tag);
        check_eq({tag, "_count"}, 18'(seen.size()), 18'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < seen.size()) check_eq(tag, seen[i], exp_q[i]);
        end
        seen.delete();
        exp_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        data_in  = 16'd1234;
        model_reset();
        #2;
        check_eq("reset_out", data_out, 18'd0);
        check_eq("reset_done", {17'd0, calculation_done}, 18'd0);

        // Held reset with enable high: no capture, outputs stay zero.
        drive_cycle(1'b0, 1'b1, 16'd1234);
        drive_cycle(1'b0, 1'b1, 16'd1234);
        seen.delete();

        // Step response.
        for (int i = 0; i < 25; i++) drive_cycle(1'b1, 1'b1, 16'd1);
        exp_q = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd4};
        check_seq("step");

        // Impulse response.
        async_reset();
        drive_cycle(1'b0, 1'b0, 16'd0);
        drive_cycle(1'b1, 1'b1, 16'd100);
        for (int i = 0; i < 29; i++) drive_cycle(1'b1, 1'b1, 16'd0);
        exp_q = '{18'd100, 18'd100, 18'd100, 18'd100, 18'd0, 18'd0};
        check_seq("impulse");

        // Full-scale input.
        async_reset();
        drive_cycle(1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 25; i++) drive_cycle(1'b1, 1'b1, 16'hFFFF);
        exp_q = '{18'd65535, 18'd131070, 18'd196605, 18'd262140, 18'd262140};
        check_seq("full_scale");

        // Enable gating: load 0,1,2,3, drop enable during the last sum, then resume with 9.
        async_reset();
        drive_cycle(1'b0, 1'b0, 16'd0);
        for (int s = 0; s < 3; s++) begin
            drive_cycle(1'b1, 1'b1, 16'(s));
            for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 16'hDEAD);
        end
        drive_cycle(1'b1, 1'b1, 16'd3);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 16'hBEEF);
        check_eq("gate_last_result", data_out, 18'd6);
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 16'd555);
        check_eq("gate_hold", data_out, 18'd6);
        drive_cycle(1'b1, 1'b1, 16'd9);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 16'd0);
        check_eq("gate_resume", data_out, 18'd15);
        check_eq("gate_resume_done", {17'd0, calculation_done}, 18'd1);

        // Reset in the middle of an accumulation.
        drive_cycle(1'b1, 1'b1, 16'd500);
        drive_cycle(1'b1, 1'b1, 16'd0);
        drive_cycle(1'b1, 1'b1, 16'd0);
        async_reset();
        drive_cycle(1'b0, 1'b1, 16'd1234);
        drive_cycle(1'b1, 1'b1, 16'd7);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 16'd0);
        check_eq("mid_reset_result", data_out, 18'd7);
        check_eq("mid_reset_done", {17'd0, calculation_done}, 18'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic rst;
            logic en;
            rst = ($urandom_range(0, 99) != 0);
            en  = ($urandom_range(0, 3) != 0);
            drive_cycle(rst, en, 16'($urandom));
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
